adc_uart_tx: RTL and testbench



---
 rtl/adc_uart_tx.sv | 124 ++++++++++++
 tb/tb_adc_uart_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/adc_uart_tx.sv
// UART 8N1 serializer for MCP3201 samples: captures on chip_select rise and
// sends {SYNC_NIBBLE, s[11:8]} then s[7:0], handshaking through serial_ready.
module adc_uart_tx #(
    parameter int          n_bits       = 12,
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [3:0]  SYNC_NIBBLE  = 4'hA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chip_select,
    input  logic [n_bits-1:0] datos_adc,
    output logic              serial_ready,
    output logic              tx_out
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic          byte_q;
    logic [11:0]   sample_q;
    logic          tx_q;
    logic          ready_q;
    logic          cs_s1_q, cs_s2_q, cs_prev_q;

    logic [11:0]   sample_d;
    logic [7:0]    cur_byte;
    logic          cs_rise;
    logic          baud_done;

    assign sample_d  = 12'(datos_adc);
    assign cs_rise   = cs_s2_q & ~cs_prev_q;
    assign baud_done = (baud_q == '0);

    always_comb begin
        cur_byte = byte_q ? sample_q[7:0] : {SYNC_NIBBLE, sample_q[11:8]};
    end

    // NOTE: every register here is updated with <= so all flops see the
    // pre-edge values of each other, exactly like the hardware they model.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= 1'b0;
            sample_q  <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            // NOTE: synchronizer resets high so a chip_select already high
            // at reset release is not mistaken for a rising edge.
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            cs_s1_q   <= chip_select;
            cs_s2_q   <= cs_s1_q;
            cs_prev_q <= cs_s2_q;

            case (state_q)
                IDLE: begin
                    if (cs_rise) begin
                        sample_q <= sample_d;
                        byte_q   <= 1'b0;
                        bit_q    <= '0;
                        baud_q   <= BAUD_LOAD;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_q  <= BAUD_LOAD;
                        bit_q   <= '0;
                        tx_q    <= cur_byte[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= BAUD_LOAD;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= cur_byte[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        if (!byte_q) begin
                            // byte1 start bit follows byte0 stop with no gap
                            byte_q  <= 1'b1;
                            baud_q  <= BAUD_LOAD;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_out       = tx_q;
    assign serial_ready = ready_q;

endmodule

// File: tb/tb_adc_uart_tx.sv
// Self-checking bench for adc_uart_tx: directed table, reset corner cases and
// random samples compared cycle by cycle against an expected-line model.
module tb_adc_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 20 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_a, cs_b;
    logic [11:0] datos_a;
    logic [9:0]  datos_b;
    logic        ready_a, tx_a, ready_b, tx_b;

    always #5 clk = ~clk;

    adc_uart_tx #(.n_bits(12), .CLKS_PER_BIT(CPB), .SYNC_NIBBLE(4'hA)) dut_a (
        .clk(clk), .reset(reset), .chip_select(cs_a), .datos_adc(datos_a),
        .serial_ready(ready_a), .tx_out(tx_a)
    );

    adc_uart_tx #(.n_bits(10), .CLKS_PER_BIT(CPB), .SYNC_NIBBLE(4'hA)) dut_b (
        .clk(clk), .reset(reset), .chip_select(cs_b), .datos_adc(datos_b),
        .serial_ready(ready_b), .tx_out(tx_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [11:0] sample;
        bit          use_b;
        bit          toggle;
        int          low_cycles;
        int          post_idle;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line level c clocks after the start bit began.
    function automatic logic line_bit(input logic [7:0] b0, input logic [7:0] b1, input int c);
        int         bp  = c / CPB;
        int         pos = bp % 10;
        logic [7:0] byt = (bp / 10 == 0) ? b0 : b1;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos-1];
    endfunction

    function automatic logic get_tx(input bit use_b);
        return use_b ? tx_b : tx_a;
    endfunction

    function automatic logic get_ready(input bit use_b);
        return use_b ? ready_b : ready_a;
    endfunction

    task automatic set_cs(input bit use_b, input logic v);
        if (use_b) cs_b = v;
        else       cs_a = v;
    endtask

    task automatic run_frame(input bit use_b, input logic [11:0] s, input logic [7:0] b0,
                             input logic [7:0] b1, input bit toggle, input int low_cycles,
                             input int post_idle, input int abort_at);
        bit aborted = 1'b0;
        if (use_b) datos_b = s[9:0];
        else       datos_a = s;
        set_cs(use_b, 1'b0);
        repeat (low_cycles) @(posedge clk);
        #1;
        set_cs(use_b, 1'b1);
        @(posedge clk); @(negedge clk);
        check("edge_k tx", get_tx(use_b), 1'b1);
        check("edge_k ready", get_ready(use_b), 1'b1);
        @(posedge clk); @(negedge clk);
        check("edge_k1 tx", get_tx(use_b), 1'b1);
        for (int c = 0; c < FRAME; c++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("line s=%03h c=%0d", s, c), get_tx(use_b), line_bit(b0, b1, c));
            check($sformatf("busy s=%03h c=%0d", s, c), get_ready(use_b), 1'b0);
            if (c == 0) begin
                if (use_b) datos_b = 10'($urandom);
                else       datos_a = 12'($urandom);
            end
            if (toggle && (c == 10 || c == 40)) set_cs(use_b, 1'b0);
            if (toggle && (c == 14 || c == 46)) set_cs(use_b, 1'b1);
            if (c == abort_at) begin
                reset = 1'b1;
                @(posedge clk); @(negedge clk);
                check("abort tx", get_tx(use_b), 1'b1);
                check("abort ready", get_ready(use_b), 1'b1);
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("ready_back s=%03h", s), get_ready(use_b), 1'b1);
            check($sformatf("idle_tx s=%03h", s), get_tx(use_b), 1'b1);
        end
        for (int i = 0; i < post_idle; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("post_idle tx i=%0d", i), get_tx(use_b), 1'b1);
            check($sformatf("post_idle ready i=%0d", i), get_ready(use_b), 1'b1);
        end
    endtask

    initial begin
        logic [11:0] s;
        bit          ub;

        tbl[0] = '{12'hABC, 1'b0, 1'b0, 3, 8, 8'hAA, 8'hBC};
        tbl[1] = '{12'h123, 1'b0, 1'b1, 3, 8, 8'hA1, 8'h23};
        tbl[2] = '{12'hFFF, 1'b0, 1'b0, 2, 0, 8'hAF, 8'hFF};
        tbl[3] = '{12'h000, 1'b0, 1'b0, 1, 8, 8'hA0, 8'h00};
        tbl[4] = '{12'h3FF, 1'b1, 1'b0, 3, 8, 8'hA3, 8'hFF};

        reset   = 1'b1;
        cs_a    = 1'b1;
        cs_b    = 1'b1;
        datos_a = '0;
        datos_b = '0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("reset tx_a", tx_a, 1'b1);
            check("reset ready_a", ready_a, 1'b1);
            check("reset tx_b", tx_b, 1'b1);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            check("post_reset tx_a", tx_a, 1'b1);
            check("post_reset ready_a", ready_a, 1'b1);
            check("post_reset tx_b", tx_b, 1'b1);
        end

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].use_b, tbl[i].sample, tbl[i].b0, tbl[i].b1, tbl[i].toggle,
                      tbl[i].low_cycles, tbl[i].post_idle, -1);
        end

        // reset during byte0 data bit 3, then one clean frame
        run_frame(1'b0, 12'h5C3, 8'hA5, 8'hC3, 1'b0, 2, 6, 18);
        run_frame(1'b0, 12'h5C3, 8'hA5, 8'hC3, 1'b0, 2, 4, -1);

        for (int i = 0; i < 20; i++) begin
            ub = 1'($urandom_range(0, 1));
            s  = 12'($urandom);
            if (ub) s = s & 12'h3FF;
            run_frame(ub, s, {4'hA, s[11:8]}, s[7:0], 1'($urandom_range(0, 1)),
                      $urandom_range(1, 5), $urandom_range(0, 3), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
